imem_fetch: RTL and testbench

//  Parametrised instruction memory with valid/ready fetch port, program-loader write port and flush.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/imem_ram.sv | 30 +++
 rtl/imem_fetch.sv | 133 +++++++++++++
 tb/tb_imem_fetch.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I core types: canonical NOP encoding, fetch fault codes and
// the instruction-memory controller states.
package riscv_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'b00,
        FLT_MISALIGN = 2'b01,
        FLT_RANGE    = 2'b10
    } fetch_fault_e;

    typedef enum logic {
        IM_FETCH = 1'b0,
        IM_LOAD  = 1'b1
    } imem_state_e;

endpackage

// File: rtl/imem_ram.sv
// 1R1W synchronous RAM with registered read and no reset, written so that
// synthesis maps it onto a block RAM. Contents survive core resets.
module imem_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port plus registered read port; the read register holds its
    // value whenever re is low so a stalled response stays stable.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_fetch.sv
// Instruction memory front end: valid/ready fetch from a byte PC, one-cycle
// registered response with alignment/range fault tagging, a program-loader
// write port that temporarily blocks fetch, and a flush for redirects.
module imem_fetch
    import riscv_pkg::*;
#(
    parameter int                    I_WIDTH     = 32,
    parameter int                    PC_WIDTH    = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [PC_WIDTH-1:0]   BASE_ADDR   = '0,
    localparam int                   AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [PC_WIDTH-1:0] req_pc,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [I_WIDTH-1:0]  rsp_instr,
    output logic [PC_WIDTH-1:0] rsp_pc,
    output logic [1:0]          rsp_fault,
    input  logic                ld_en,
    input  logic [AW-1:0]       ld_addr,
    input  logic [I_WIDTH-1:0]  ld_data,
    output logic                ld_busy
);

    imem_state_e         state, next_state;
    fetch_fault_e        req_fault, fault_q;
    logic                accept;
    logic                rd_en;
    logic                from_ram;
    logic [PC_WIDTH:0]   pc_ext, lo_ext, hi_ext;
    logic [PC_WIDTH-1:0] offset;
    logic [AW-1:0]       idx;
    logic [I_WIDTH-1:0]  ram_q;

    // One extra bit keeps BASE_ADDR + 4*DEPTH_WORDS from wrapping at the top
    // of the address space.
    assign pc_ext = {1'b0, req_pc};
    assign lo_ext = {1'b0, BASE_ADDR};
    assign hi_ext = lo_ext + ((PC_WIDTH + 1)'(DEPTH_WORDS) << 2);
    assign offset = req_pc - BASE_ADDR;
    assign idx    = AW'(offset >> 2);

    // Fault classification; misalignment wins over out-of-range.
    always_comb begin
        req_fault = FLT_NONE;
        if (req_pc[1:0] != 2'b00) begin
            req_fault = FLT_MISALIGN;
        end else if ((pc_ext < lo_ext) || (pc_ext >= hi_ext)) begin
            req_fault = FLT_RANGE;
        end
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IM_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next state and handshake: loader activity, a flush, or an undrained
    // response all hold off new requests.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        ld_busy    = 1'b0;
        case (state)
            IM_FETCH: begin
                req_ready = ~ld_en & ~flush & (~rsp_valid | rsp_ready);
                if (ld_en) begin
                    next_state = IM_LOAD;
                end
            end
            IM_LOAD: begin
                ld_busy = 1'b1;
                if (!ld_en) begin
                    next_state = IM_FETCH;
                end
            end
            default: next_state = IM_FETCH;
        endcase
    end

    assign accept = req_valid & req_ready;
    // Faulted requests never touch the RAM.
    assign rd_en  = accept & (req_fault == FLT_NONE);

    // Loader writes on every ld_en cycle, including the one that enters LOAD,
    // so a burst loses no words. ld_en blocks accept, so reads never collide.
    imem_ram #(
        .WIDTH (I_WIDTH),
        .DEPTH (DEPTH_WORDS)
    ) u_ram (
        .clk   (clk),
        .we    (ld_en),
        .waddr (ld_addr),
        .wdata (ld_data),
        .re    (rd_en),
        .raddr (idx),
        .rdata (ram_q)
    );

    // Response register: loads on accept, drops on flush or consumption,
    // otherwise holds. from_ram selects RAM data vs NOP so reset and faults
    // show NOP without needing a reset on the RAM read register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_pc    <= '0;
            fault_q   <= FLT_NONE;
            from_ram  <= 1'b0;
        end else if (flush) begin
            rsp_valid <= 1'b0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_pc    <= req_pc;
            fault_q   <= req_fault;
            from_ram  <= (req_fault == FLT_NONE);
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    assign rsp_instr = from_ram ? ram_q : I_WIDTH'(RV_NOP);
    assign rsp_fault = fault_q;

endmodule

// File: tb/tb_imem_fetch.sv
// Directed bench for imem_fetch with a cycle model of the handshake and a
// scoreboard queue of expected responses.
module tb_imem_fetch;

    localparam int DEPTH = 1024;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_pc;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_instr;
    logic [31:0]   rsp_pc;
    logic [1:0]    rsp_fault;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;
    logic          ld_busy;

    imem_fetch #(
        .I_WIDTH     (32),
        .PC_WIDTH    (32),
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (32'h0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_pc    (req_pc),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_pc    (rsp_pc),
        .rsp_fault (rsp_fault),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_busy   (ld_busy)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [65:0] sb_q [$];   // {instr, pc, fault}
    logic [31:0] mdl [DEPTH];
    logic        m_valid = 1'b0;
    logic        m_load  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [65:0] expect_of(input logic [31:0] pc);
        logic [1:0]  f;
        logic [31:0] ins;
        if (pc[1:0] != 2'b00)         f = 2'b01;
        else if (pc >= 32'(4 * DEPTH)) f = 2'b10;
        else                          f = 2'b00;
        ins = (f != 2'b00) ? 32'h0000_0013 : mdl[pc[AW+1:2]];
        return {ins, pc, f};
    endfunction

    // Compare DUT against the model at the falling edge, then advance the model.
    task automatic sample();
        logic        m_rdy;
        logic [65:0] e;
        @(negedge clk);
        if (!rst_n) begin
            sb_q.delete();
            m_valid = 1'b0;
            m_load  = 1'b0;
            return;
        end
        m_rdy = !m_load && !ld_en && !flush && (!m_valid || rsp_ready);
        chk("req_ready", 64'(req_ready), 64'(m_rdy));
        chk("ld_busy",   64'(ld_busy),   64'(m_load));
        chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
        if (m_valid && sb_q.size() > 0) begin
            e = sb_q[0];
            chk("rsp_instr", 64'(rsp_instr), 64'(e[65:34]));
            chk("rsp_pc",    64'(rsp_pc),    64'(e[33:2]));
            chk("rsp_fault", 64'(rsp_fault), 64'(e[1:0]));
        end
        if (ld_en) mdl[ld_addr] = ld_data;
        if (flush) begin
            sb_q.delete();
            m_valid = 1'b0;
        end else begin
            if (m_valid && rsp_ready) begin
                void'(sb_q.pop_front());
                m_valid = 1'b0;
            end
            if (req_valid && m_rdy) begin
                sb_q.push_back(expect_of(req_pc));
                m_valid = 1'b1;
            end
        end
        m_load = ld_en;
    endtask

    task automatic tick();
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        chk({tag, "_rsp_instr"}, 64'(rsp_instr), 64'h13);
        chk({tag, "_rsp_pc"},    64'(rsp_pc),    64'(0));
        chk({tag, "_rsp_fault"}, 64'(rsp_fault), 64'(0));
        chk({tag, "_ld_busy"},   64'(ld_busy),   64'(0));
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_pc = '0;
        rsp_ready = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        chk("reset_req_ready", 64'(req_ready), 64'(1));
        rst_n = 1'b1;

        // Load words 0..3
        for (int i = 0; i < 4; i++) begin
            ld_en = 1'b1; ld_addr = AW'(i); ld_data = 32'((i + 1) * 'h11);
            tick();
            chk("load_busy", 64'(ld_busy), 64'(1));
        end
        ld_en = 1'b0;
        #2 chk("drain_req_ready", 64'(req_ready), 64'(0));
        tick();

        // Back-to-back stream
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_pc = 32'(4 * i);
            tick();
            chk("stream_valid", 64'(rsp_valid), 64'(1));
        end
        req_valid = 1'b0;
        tick();

        // Stall on PC 4 response
        req_valid = 1'b1; req_pc = 32'h0; tick();
        req_pc = 32'h4; tick();
        rsp_ready = 1'b0; req_pc = 32'h8;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("stall_req_ready", 64'(req_ready), 64'(0));
            chk("stall_instr",     64'(rsp_instr), 64'h22);
            chk("stall_pc",        64'(rsp_pc),    64'h4);
            tick();
        end
        rsp_ready = 1'b1; tick();
        req_valid = 1'b0; tick();

        // Faults
        req_valid = 1'b1; req_pc = 32'h6; tick();
        chk("misalign_fault", 64'(rsp_fault), 64'h1);
        chk("misalign_instr", 64'(rsp_instr), 64'h13);
        req_pc = 32'(4 * DEPTH); tick();
        chk("range_fault", 64'(rsp_fault), 64'h2);
        chk("range_instr", 64'(rsp_instr), 64'h13);
        req_pc = 32'(4 * DEPTH + 1); tick();
        chk("priority_fault", 64'(rsp_fault), 64'h1);
        req_valid = 1'b0; tick();

        // Flush with a held response and a pending request
        rsp_ready = 1'b0; req_valid = 1'b1; req_pc = 32'h8; tick();
        flush = 1'b1; req_pc = 32'hC;
        #2 chk("flush_req_ready", 64'(req_ready), 64'(0));
        tick();
        flush = 1'b0;
        chk("flush_dropped", 64'(rsp_valid), 64'(0));
        rsp_ready = 1'b1;
        #2 chk("retry_req_ready", 64'(req_ready), 64'(1));
        tick();
        req_valid = 1'b0; tick();

        // Loader interrupts a stream with a held response
        rsp_ready = 1'b0; req_valid = 1'b1; req_pc = 32'h0; tick();
        req_pc = 32'h4; ld_en = 1'b1; ld_addr = AW'(4); ld_data = 32'h55; rsp_ready = 1'b1;
        #2 chk("ld_block_req_ready", 64'(req_ready), 64'(0));
        tick();
        ld_addr = AW'(5); ld_data = 32'h66; tick();
        ld_en = 1'b0; tick();
        req_pc = 32'h10; tick();
        req_pc = 32'h14; tick();
        req_valid = 1'b0; tick();

        // Reset with a response held
        rsp_ready = 1'b0; req_valid = 1'b1; req_pc = 32'h8; tick();
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1 chk_reset_outputs("rst_stream");
        tick();
        rst_n = 1'b1;

        // Reset during a load
        ld_en = 1'b1; ld_addr = AW'(6); ld_data = 32'h77; tick();
        ld_en = 1'b0; rst_n = 1'b0;
        #1 chk_reset_outputs("rst_load");
        tick();
        rst_n = 1'b1;

        // RAM contents retained across reset
        rsp_ready = 1'b1; req_valid = 1'b1; req_pc = 32'h8; tick();
        chk("retained_pc8", 64'(rsp_instr), 64'h33);
        req_pc = 32'h18; tick();
        chk("retained_pc24", 64'(rsp_instr), 64'h77);
        req_valid = 1'b0;

        // Bounded drain of anything left outstanding
        for (int i = 0; i < 10 && m_valid; i++) tick();
        tick();
        chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
